// File: rtl/clock_pkg.sv
// Shared BCD types and helpers for the modulo-N BCD counter.
package clock_pkg;

  // One decimal digit held in BCD.
  typedef logic [3:0] bcd_t;

  // Largest legal value of a BCD digit.
  localparam bcd_t BCD_MAX = 4'd9;

  // Splits a binary value 0..99 into {tens, units} BCD digits.
  function automatic logic [7:0] bin_to_bcd(input int unsigned value);
    bcd_t tens;
    bcd_t units;
    tens  = 4'(value / 10);
    units = 4'(value % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: load / count up / count down / hold.
// Counting up wraps from wrap_max to 0; counting down wraps from 0 to 9.
// at_max / at_zero are unqualified state flags the parent uses to chain
// decades and to detect the overall modulus boundary.
module bcd_digit
  import clock_pkg::*;
#(
  parameter bcd_t RESET_DIGIT = 4'd0
) (
  input  logic ck,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t load_d,
  input  bcd_t wrap_max,
  output bcd_t q,
  output logic at_max,
  output logic at_zero
);

  assign at_max  = (q == wrap_max);
  assign at_zero = (q == 4'd0);

  // Digit register: load wins over inc, inc over dec, otherwise hold.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      q <= RESET_DIGIT;
    end else if (load) begin
      q <= load_d;
    end else if (inc) begin
      q <= at_max ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= at_zero ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter counting modulo MODULUS (2..100).
// Per cycle: load > exactly-one-of(inc, dec) > hold. inc and dec are
// single-cycle requests sampled on the rising edge; there is no ready,
// every request is consumed on the edge that samples it.
// carry_out / borrow_out are combinational so a following stage can take
// them directly as its inc / dec in the same cycle.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MODULUS   = 60,
  parameter int RESET_VAL = 0
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_d0,
  input  logic [3:0] load_d1,
  output logic [3:0] display0,
  output logic [3:0] display1,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       load_err
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS %0d outside 2..100", MODULUS);
  end
  if (RESET_VAL < 0 || RESET_VAL > MODULUS - 1) begin : g_bad_reset_val
    $error("bcd_mod_counter: RESET_VAL %0d outside 0..MODULUS-1", RESET_VAL);
  end

  localparam logic [7:0] MAX_BCD = bin_to_bcd(MODULUS - 1);
  localparam logic [7:0] RST_BCD = bin_to_bcd(RESET_VAL);
  localparam bcd_t       MAX_D1  = MAX_BCD[7:4];
  localparam bcd_t       MAX_D0  = MAX_BCD[3:0];
  localparam bcd_t       RST_D1  = RST_BCD[7:4];
  localparam bcd_t       RST_D0  = RST_BCD[3:0];

  logic [7:0] load_bin;
  logic       load_ok;
  logic       step_up;
  logic       step_dn;
  logic       wrap_dn;
  logic       at_max;
  logic       at_zero;
  logic       u_top;
  logic       u_zero;
  logic       t_top;
  logic       t_zero;
  bcd_t       u_wrap;

  // Loaded value in binary; digits up to 0xF keep this below 256.
  assign load_bin = 8'(load_d1) * 8'd10 + 8'(load_d0);
  assign load_ok  = load && (load_d0 <= BCD_MAX) && (load_d1 <= BCD_MAX)
                    && (load_bin < 8'(MODULUS));

  assign step_up = ~load & inc & ~dec;
  assign step_dn = ~load & dec & ~inc;

  assign at_max  = u_top & t_top;
  assign at_zero = u_zero & t_zero;

  // Going below zero cannot be expressed as a per-digit wrap (the units
  // digit would land on 9), so it is done as a load of MODULUS-1.
  assign wrap_dn = step_dn & at_zero;

  // Units digit wraps at 9, except in the top decade where it wraps at
  // the units digit of MODULUS-1 so the whole count rolls over to 00.
  assign u_wrap = t_top ? MAX_D0 : BCD_MAX;

  bcd_digit #(.RESET_DIGIT(RST_D0)) u_units (
    .ck       (ck),
    .rst      (rst),
    .inc      (step_up),
    .dec      (step_dn),
    .load     (load_ok | wrap_dn),
    .load_d   (load_ok ? load_d0 : MAX_D0),
    .wrap_max (u_wrap),
    .q        (display0),
    .at_max   (u_top),
    .at_zero  (u_zero)
  );

  bcd_digit #(.RESET_DIGIT(RST_D1)) u_tens (
    .ck       (ck),
    .rst      (rst),
    .inc      (step_up & u_top),
    .dec      (step_dn & u_zero),
    .load     (load_ok | wrap_dn),
    .load_d   (load_ok ? load_d1 : MAX_D1),
    .wrap_max (MAX_D1),
    .q        (display1),
    .at_max   (t_top),
    .at_zero  (t_zero)
  );

  assign carry_out  = step_up & at_max & ~rst;
  assign borrow_out = wrap_dn & ~rst;

  // One-cycle flag for a load request whose digits or value were illegal.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      load_err <= 1'b0;
    end else begin
      load_err <= load & ~load_ok;
    end
  end

endmodule
